// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'h4;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: power-of-2 circular FIFO with flush.
// Head reads as zero while empty so the decode outputs are clean after reset/flush.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push && !i_flush;
    assign w_rd_en = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + AW'(1);
            if (w_rd_en) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= i_data;
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;

    // The fetch credit rule reserves a slot for every in-flight response.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_wr_en && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited imem requests, in-order response buffer, redirect flush.
// Define FETCH_PERF_EN to add the stall_cnt decode-starvation counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fpc;
    logic [31:0]   w_fpc_nxt;
    logic [31:0]   r_rpc;
    logic [31:0]   w_rpc_nxt;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] w_outst_nxt;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_cnt;
    logic [CW:0]   w_inflight;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    // Responses return in order and addresses are sequential between redirects,
    // so r_rpc tracks the address of the oldest outstanding request.
    assign w_inflight     = {1'b0, r_outst} + {1'b0, w_cnt};
    assign imem_req_valid = rst && (r_state == ST_RUN) && !redirect_valid
                            && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fpc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_push         = imem_rsp_valid && (r_state == ST_RUN) && !redirect_valid;
    assign w_pop          = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (w_cnt != '0);
    assign instr       = w_head[63:32];
    assign instr_pc    = w_head[31:0];

    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_rpc_nxt   = r_rpc;
        w_drop_nxt  = r_drop;
        w_outst_nxt = r_outst + CW'(w_accept) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            w_fpc_nxt   = redirect_pc;
            w_rpc_nxt   = redirect_pc;
            w_drop_nxt  = w_outst_nxt;
            w_state_nxt = (w_outst_nxt != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (w_accept) w_fpc_nxt = r_fpc + PC_INC;
            if (w_push)   w_rpc_nxt = r_rpc + PC_INC;
            if (r_state == ST_FLUSH) begin
                if (imem_rsp_valid) w_drop_nxt = r_drop - CW'(1);
                if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
            r_rpc   <= w_rpc_nxt;
            r_outst <= w_outst_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({imem_rsp_data, r_rpc}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_cnt)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (instr_ready && !instr_valid && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with an in-order 1-cycle memory model.
// Define FETCH_PERF_EN to also exercise stall_cnt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_acc;
    int unsigned n_stall;
    logic        rsp_en;
    logic [31:0] pend[$];
    logic [31:0] issued[$];
    logic [31:0] seen[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Samples handshakes before the edge, then updates the memory model after it.
    task automatic tick();
        logic        acc;
        logic        hs;
        logic [31:0] a;
        logic [31:0] p;
        logic [31:0] d;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        hs  = instr_valid && instr_ready;
        p   = instr_pc;
        d   = instr;
        if (instr_ready && !instr_valid) n_stall++;
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            pend.push_back(a);
            issued.push_back(a);
            n_acc++;
        end
        if (hs) begin
            seen.push_back(p);
            check("instr_data", d, mem_data(p));
        end
        if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        issued.delete();
        seen.delete();
        n_acc   = 0;
        n_stall = 0;
        rst     = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        rsp_en         = 1'b1;

        // Sequential fetch after reset release
        apply_reset();
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr", imem_req_addr, 32'h0);
        tick();
        check("t1_lat_empty", 32'(instr_valid), 32'd0);
        tick();
        check("t1_lat_valid", 32'(instr_valid), 32'd1);
        check("t1_first_pc", instr_pc, 32'h0);
        check("t1_first_instr", instr, mem_data(32'h0));
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            check("t1_req_seq", issued[i], 32'(i * 4));
            check("t1_pc_seq", seen[i], 32'(i * 4));
        end

        // Decode stalled: credits cap the requests at DEPTH
        apply_reset();
        instr_ready = 1'b0;
        repeat (12) tick();
        check("t2_accepts", 32'(n_acc), 32'd4);
        check("t2_cnt", 32'(u_dut.w_cnt), 32'd4);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        seen.delete();
        repeat (4) tick();
        for (int i = 0; i < 4; i++) check("t2_drain_pc", seen[i], 32'(i * 4));
        rsp_en = 1'b0;
        repeat (2) tick();
        apply_reset();
        rsp_en = 1'b1;
        check("t2_rst_req_addr", imem_req_addr, 32'h0);
        check("t2_rst_req_valid", 32'(imem_req_valid), 32'd1);
        tick();
        check("t2_rst_no_stale", 32'(instr_valid), 32'd0);
        tick();
        check("t2_rst_pc", instr_pc, 32'h0);

        // Redirect with two requests outstanding
        apply_reset();
        rsp_en = 1'b0;
        repeat (2) tick();
        imem_req_ready = 1'b0;
        rsp_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        check("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t3_state_flush", 32'(u_dut.r_state), 32'd1);
        check("t3_drop", 32'(u_dut.r_drop), 32'd2);
        imem_req_ready = 1'b1;
        #1;
        check("t3_flush_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check("t3_state_flush2", 32'(u_dut.r_state), 32'd1);
        check("t3_drop2", 32'(u_dut.r_drop), 32'd1);
        check("t3_flush_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t3_state_run", 32'(u_dut.r_state), 32'd0);
        check("t3_req_valid", 32'(imem_req_valid), 32'd1);
        check("t3_req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b0;
        tick();
        check("t3_addr_stable", imem_req_addr, 32'h100);
        check("t3_valid_stable", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        tick();
        tick();
        check("t3_first_valid", 32'(instr_valid), 32'd1);
        check("t3_first_pc", instr_pc, 32'h100);
        check("t3_first_instr", instr, mem_data(32'h100));

        // Redirect colliding with a response and a decode handshake
        apply_reset();
        rsp_en      = 1'b0;
        instr_ready = 1'b0;
        tick();
        rsp_en = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        instr_ready    = 1'b1;
        #1;
        check("t4_outst", 32'(u_dut.r_outst), 32'd2);
        check("t4_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        check("t4_hs_valid", 32'(instr_valid), 32'd1);
        check("t4_hs_pc", instr_pc, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_hs_done", 32'(seen.size()), 32'd1);
        check("t4_drop", 32'(u_dut.r_drop), 32'd1);
        check("t4_state_flush", 32'(u_dut.r_state), 32'd1);
        check("t4_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t4_state_run", 32'(u_dut.r_state), 32'd0);
        check("t4_req_addr", imem_req_addr, 32'h200);
        check("t4_req_valid", 32'(imem_req_valid), 32'd1);

        // PC wrap at the top of the address space
        apply_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t5_state_run", 32'(u_dut.r_state), 32'd0);
        check("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        check("t5_wrap_addr", imem_req_addr, 32'h0);
        tick();
        check("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
        tick();
        check("t5_pc_wrap", instr_pc, 32'h0);

`ifdef FETCH_PERF_EN
        // Decode starved while memory is not ready
        apply_reset();
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        check("t6_stall_rst", stall_cnt, 32'd0);
        repeat (10) tick();
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("t6_instr_arrived", 32'(instr_valid), 32'd1);
        check("t6_stall_cnt", stall_cnt, 32'(n_stall));
        check("t6_stall_min", 32'(stall_cnt >= 32'd10), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
